// File: rtl/secim_sayim_kontrol.sv
// Sequential election count controller sharing one external sandik evaluator across four boxes.
// Optional SECIM_TEKRAR_SAYIM_EN: evaluate each box twice and flag disagreement on hata.
module secim_sayim_kontrol #(
    parameter int unsigned BEKLEME = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] T,
    input  logic [7:0] H,
    output logic [1:0] sandik_T,
    output logic [1:0] sandik_H,
    input  logic       sandik_S,
    output logic [1:0] sandik_sec,
    output logic       mesgul,
    output logic       bitti,
    output logic [3:0] sonuc,
    output logic       S
`ifdef SECIM_TEKRAR_SAYIM_EN
   ,output logic       hata
`endif
);

    typedef enum logic [1:0] {BOSTA, SAY, KARAR} durum_t;

    localparam logic [3:0] BEKLEME_W = 4'(BEKLEME);

    durum_t     durum_q, durum_d;
    logic [7:0] t_lat_q, t_lat_d, h_lat_q, h_lat_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] tmp_q, tmp_d;
    logic [1:0] sandik_t_q, sandik_t_d, sandik_h_q, sandik_h_d;
    logic [1:0] sec_q, sec_d;
    logic       mesgul_q, mesgul_d;
    logic       bitti_q, bitti_d;
    logic [3:0] sonuc_q, sonuc_d;
    logic       s_q, s_d;
    logic       pencere_son;
`ifdef SECIM_TEKRAR_SAYIM_EN
    logic       tur_q, tur_d;
    logic       fark_q, fark_d;
    logic       hata_q, hata_d;
`endif

    function automatic logic [1:0] dilim(input logic [7:0] v, input logic [1:0] i);
        case (i)
            2'd0:    return v[7:6];
            2'd1:    return v[5:4];
            2'd2:    return v[3:2];
            default: return v[1:0];
        endcase
    endfunction

    always_comb begin
        durum_d     = durum_q;
        t_lat_d     = t_lat_q;
        h_lat_d     = h_lat_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        tmp_d       = tmp_q;
        sandik_t_d  = sandik_t_q;
        sandik_h_d  = sandik_h_q;
        sec_d       = sec_q;
        mesgul_d    = mesgul_q;
        bitti_d     = 1'b0;
        sonuc_d     = sonuc_q;
        s_d         = s_q;
        pencere_son = 1'b0;
`ifdef SECIM_TEKRAR_SAYIM_EN
        tur_d       = tur_q;
        fark_d      = fark_q;
        hata_d      = hata_q;
`endif
        case (durum_q)
            BOSTA: begin
                sandik_t_d = '0;
                sandik_h_d = '0;
                sec_d      = '0;
                mesgul_d   = 1'b0;
                if (start) begin
                    // Box 0 slice is taken straight from the inputs so it is on the bus in the first SAY cycle.
                    t_lat_d    = T;
                    h_lat_d    = H;
                    idx_d      = '0;
                    cnt_d      = '0;
                    sandik_t_d = T[7:6];
                    sandik_h_d = H[7:6];
                    mesgul_d   = 1'b1;
                    durum_d    = SAY;
`ifdef SECIM_TEKRAR_SAYIM_EN
                    tur_d      = 1'b0;
                    fark_d     = 1'b0;
`endif
                end
            end
            SAY: begin
                if (cnt_q == BEKLEME_W) begin
`ifdef SECIM_TEKRAR_SAYIM_EN
                    if (!tur_q) begin
                        tmp_d[~idx_q] = sandik_S;
                        tur_d         = 1'b1;
                        cnt_d         = '0;
                    end else begin
                        fark_d      = fark_q | (tmp_q[~idx_q] != sandik_S);
                        tur_d       = 1'b0;
                        pencere_son = 1'b1;
                    end
`else
                    tmp_d[~idx_q] = sandik_S;
                    pencere_son   = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
                if (pencere_son) begin
                    if (idx_q == 2'd3) begin
                        sandik_t_d = '0;
                        sandik_h_d = '0;
                        sec_d      = '0;
                        durum_d    = KARAR;
                    end else begin
                        idx_d      = idx_q + 2'd1;
                        cnt_d      = '0;
                        sandik_t_d = dilim(t_lat_q, idx_q + 2'd1);
                        sandik_h_d = dilim(h_lat_q, idx_q + 2'd1);
                        sec_d      = idx_q + 2'd1;
                    end
                end
            end
            KARAR: begin
                sonuc_d  = tmp_q;
                s_d      = (tmp_q[0] & (tmp_q[1] | tmp_q[3] | tmp_q[2])) |
                           (tmp_q[3] & tmp_q[2] & tmp_q[1]);
                bitti_d  = 1'b1;
                mesgul_d = 1'b0;
                durum_d  = BOSTA;
`ifdef SECIM_TEKRAR_SAYIM_EN
                hata_d   = fark_q;
`endif
            end
            default: durum_d = BOSTA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            durum_q    <= BOSTA;
            t_lat_q    <= '0;
            h_lat_q    <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            tmp_q      <= '0;
            sandik_t_q <= '0;
            sandik_h_q <= '0;
            sec_q      <= '0;
            mesgul_q   <= 1'b0;
            bitti_q    <= 1'b0;
            sonuc_q    <= '0;
            s_q        <= 1'b0;
`ifdef SECIM_TEKRAR_SAYIM_EN
            tur_q      <= 1'b0;
            fark_q     <= 1'b0;
            hata_q     <= 1'b0;
`endif
        end else begin
            durum_q    <= durum_d;
            t_lat_q    <= t_lat_d;
            h_lat_q    <= h_lat_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            tmp_q      <= tmp_d;
            sandik_t_q <= sandik_t_d;
            sandik_h_q <= sandik_h_d;
            sec_q      <= sec_d;
            mesgul_q   <= mesgul_d;
            bitti_q    <= bitti_d;
            sonuc_q    <= sonuc_d;
            s_q        <= s_d;
`ifdef SECIM_TEKRAR_SAYIM_EN
            tur_q      <= tur_d;
            fark_q     <= fark_d;
            hata_q     <= hata_d;
`endif
        end
    end

    assign sandik_T   = sandik_t_q;
    assign sandik_H   = sandik_h_q;
    assign sandik_sec = sec_q;
    assign mesgul     = mesgul_q;
    assign bitti      = bitti_q;
    assign sonuc      = sonuc_q;
    assign S          = s_q;
`ifdef SECIM_TEKRAR_SAYIM_EN
    assign hata       = hata_q;
`endif

endmodule
